max2769_cfg_seq: RTL
====================

# max2769_cfg_seq

Configuration sequencer for the MAX2769 GPS front end. Holds a shadow copy of the ten 28-bit MAX2769 registers and serialises them over the chip's 3-wire interface (CS_N/SCLK/SDATA). It runs automatically after reset and again on request from the MCU-side command path. It gates the sample bridge through SAMPLE_EN so that no I/Q data is forwarded while the front end is being reprogrammed.

## Interface
- NUM_REGS, 10, number of shadow registers written per run (addresses 0..NUM_REGS-1).
- SCLK_HALF, 4, SCLK half-period in MCU_CLK cycles (H); legal range 2..255.
- MCU_CLK  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request to program all registers.
- WR_EN  in  1  shadow-register write strobe.
- WR_ADDR  in  4  shadow register address.
- WR_DATA  in  28  shadow register data.
- CFG_CS_N  out  1  MAX2769 chip select, active low.
- CFG_SCLK  out  1  MAX2769 serial clock.
- CFG_SDATA  out  1  MAX2769 serial data.
- BUSY  out  1  high while a programming run is in progress.
- DONE  out  1  one-cycle pulse at the end of each run.
- SAMPLE_EN  out  1  high when the front end is configured and the bridge may sample.

## Operation
- Shadow reset values for addresses 0..9: 0xA2919A3, 0x0550288, 0xEAFF1DC, 0x9EC0008, 0x0C00080, 0x8000070, 0x8000000, 0x10061B2, 0x1E0F401, 0x14C0402.
- WR_EN with WR_ADDR < NUM_REGS updates the shadow register on that edge. Writes with WR_ADDR >= NUM_REGS are ignored.
- Writes are accepted in any state, including while BUSY.
  - A word is copied into the shift register at its LOAD, so a write never corrupts a frame in flight.
  - A write to a not-yet-loaded address takes effect in the current run.
- Frame format: 32 bits, MSB first: D27..D0, then A3..A0.
- States:
  - IDLE
  - LOAD: latch shadow[idx] and address into the 32-bit shifter; drive CS_N low.
  - SHIFT: H cycles SCLK low, then H cycles SCLK high, per bit, for 32 bits.
  - GAP: CS_N high for 2H cycles; then idx+1 goes to LOAD, or the last idx goes to FINISH.
  - FINISH: one cycle; DONE=1. Returns to IDLE, or to LOAD with idx=0 if a start is pending.
- Leaving reset arms an automatic start: the first edge after RESET_N rises behaves as START.
- START in IDLE begins a run. START while BUSY sets a single pending flag; multiple STARTs collapse into one re-run.
- SAMPLE_EN is 0 from reset until the first DONE, 0 whenever BUSY=1, and 1 otherwise.

## Timing
- Reset values: CS_N=1, SCLK=0, SDATA=0, BUSY=0, DONE=0, SAMPLE_EN=0, pending=0, idx=0, shadow = defaults.
- START sampled at edge t:
  - t+1: CS_N=0, BUSY=1, SDATA=bit31, SCLK=0.
  - SCLK rises at t+1+H and falls at t+1+2H; SDATA changes only on SCLK falling edges (MAX2769 samples on rising).
  - CS_N rises 64H cycles after it fell, with SCLK=0. SDATA returns to 0 when CS_N is high.
- Per word: 66H cycles (64H frame + 2H gap). A run is NUM_REGS×66H cycles, then one FINISH cycle. With defaults, DONE is at t+2641.
- On the DONE cycle, BUSY=0. SAMPLE_EN=1 on the following cycle unless a pending re-run starts, in which case BUSY stays 1 and SAMPLE_EN stays 0 continuously.
- RESET_N asserted mid-frame forces all outputs to reset values immediately (asynchronously). A new automatic run starts from address 0 after release; no partial-frame completion.
- START and a write in the same cycle: the write lands first; the run sees the new value.

## Test plan
- Reset release, no other stimulus:
  - exactly 10 CS_N-low frames, each 32 SCLK rising edges.
  - First frame decodes to 0xA2919A30; last frame decodes to 0x14C04029.
  - DONE at cycle 2641; SAMPLE_EN rises at 2642.
- After idle, write addr 3 = 0x1234567, then START:
  - 4th frame = 0x12345673.
  - Other frames unchanged.
- START pulsed three times during a run: exactly one additional run; BUSY and SAMPLE_EN never toggle between runs; two DONE pulses total.
- Write addr 9 = 0x0000001 while frame 2 is shifting; same run's final frame = 0x00000019.
- RESET_N low for 3 cycles in the middle of frame 5:
  - CS_N=1, SCLK=0, SAMPLE_EN=0 immediately.
  - Restart resends from address 0 with default values.
- Write addr 12 with arbitrary data, then START: all 10 frames equal the defaults.

Source files
------------

// File: rtl/max2769_cfg_seq.sv
// MAX2769 configuration sequencer: ten-word shadow register file and a 3-wire
// serialiser that reprograms the front end after reset and on START.
module max2769_cfg_seq #(
  parameter int unsigned NUM_REGS  = 10,
  parameter int unsigned SCLK_HALF = 4
) (
  input  logic        MCU_CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        WR_EN,
  input  logic [3:0]  WR_ADDR,
  input  logic [27:0] WR_DATA,
  output logic        CFG_CS_N,
  output logic        CFG_SCLK,
  output logic        CFG_SDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        SAMPLE_EN
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam logic [8:0] DIV_HALF_C = 9'(SCLK_HALF - 1);
  localparam logic [8:0] DIV_FULL_C = 9'(2 * SCLK_HALF - 1);
  localparam logic [3:0] LAST_IDX_C = 4'(NUM_REGS - 1);
  localparam logic [4:0] LAST_BIT_C = 5'd31;

  function automatic logic [27:0] default_word(input logic [3:0] addr);
    case (addr)
      4'd0:    default_word = 28'hA2919A3;
      4'd1:    default_word = 28'h0550288;
      4'd2:    default_word = 28'hEAFF1DC;
      4'd3:    default_word = 28'h9EC0008;
      4'd4:    default_word = 28'h0C00080;
      4'd5:    default_word = 28'h8000070;
      4'd6:    default_word = 28'h8000000;
      4'd7:    default_word = 28'h10061B2;
      4'd8:    default_word = 28'h1E0F401;
      4'd9:    default_word = 28'h14C0402;
      default: default_word = 28'h0000000;
    endcase
  endfunction

  state_t      state_r;
  logic [3:0]  idx_r;
  logic [31:0] shift_r;
  logic [8:0]  div_cnt_r;
  logic [4:0]  bit_cnt_r;
  logic        cs_n_r;
  logic        sclk_r;
  logic        sdata_r;
  logic        busy_r;
  logic        done_r;
  logic        sample_en_r;
  logic        pending_r;
  logic        auto_start_r;
  logic [27:0] shadow_r [NUM_REGS];

  logic        start_s;
  logic [3:0]  load_idx_s;
  logic [27:0] load_word_s;

  // Out-of-range addresses match no word, so such writes fall through silently.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_shadow
    // one shadow word: datasheet default at reset, MCU write otherwise
    always_ff @(posedge MCU_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        shadow_r[g] <= default_word(4'(g));
      end else if (WR_EN && (WR_ADDR == 4'(g))) begin
        shadow_r[g] <= WR_DATA;
      end else begin
        shadow_r[g] <= shadow_r[g];
      end
    end
  end

  assign start_s = START | auto_start_r;

  // word and address the next frame will carry; GAP pre-selects the next index
  always_comb begin
    load_idx_s  = idx_r;
    load_word_s = 28'h0000000;
    if (state_r == ST_GAP) begin
      load_idx_s = idx_r + 4'd1;
    end else begin
      load_idx_s = idx_r;
    end
    if (32'(load_idx_s) < NUM_REGS) begin
      load_word_s = shadow_r[load_idx_s];
    end else begin
      load_word_s = 28'h0000000;
    end
  end

  // sequencer: state, frame timing, serial pins and status flags
  always_ff @(posedge MCU_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= ST_IDLE;
      idx_r        <= 4'd0;
      shift_r      <= 32'h0000_0000;
      div_cnt_r    <= 9'd0;
      bit_cnt_r    <= 5'd0;
      cs_n_r       <= 1'b1;
      sclk_r       <= 1'b0;
      sdata_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      sample_en_r  <= 1'b0;
      pending_r    <= 1'b0;
      auto_start_r <= 1'b1;
    end else begin
      auto_start_r <= 1'b0;
      done_r       <= 1'b0;
      if (start_s && (state_r != ST_IDLE)) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          idx_r <= 4'd0;
          if (start_s) begin
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shift_r     <= {load_word_s, load_idx_s};
          sdata_r     <= load_word_s[27];
          cs_n_r      <= 1'b0;
          sclk_r      <= 1'b0;
          busy_r      <= 1'b1;
          sample_en_r <= 1'b0;
          div_cnt_r   <= 9'd0;
          bit_cnt_r   <= 5'd0;
          state_r     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div_cnt_r == DIV_FULL_C) begin
            div_cnt_r <= 9'd0;
            sclk_r    <= 1'b0;
            if (bit_cnt_r == LAST_BIT_C) begin
              cs_n_r  <= 1'b1;
              sdata_r <= 1'b0;
              state_r <= ST_GAP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
              shift_r   <= {shift_r[30:0], 1'b0};
              sdata_r   <= shift_r[30];
            end
          end else begin
            div_cnt_r <= div_cnt_r + 9'd1;
            if (div_cnt_r == DIV_HALF_C) begin
              sclk_r <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (div_cnt_r == DIV_FULL_C) begin
            div_cnt_r <= 9'd0;
            if (idx_r == LAST_IDX_C) begin
              // a pending re-run keeps BUSY high straight through FINISH
              done_r  <= 1'b1;
              busy_r  <= pending_r | start_s;
              state_r <= ST_FINISH;
            end else begin
              // next frame starts on this edge so each word takes exactly 66H
              idx_r     <= load_idx_s;
              shift_r   <= {load_word_s, load_idx_s};
              sdata_r   <= load_word_s[27];
              cs_n_r    <= 1'b0;
              sclk_r    <= 1'b0;
              bit_cnt_r <= 5'd0;
              state_r   <= ST_SHIFT;
            end
          end else begin
            div_cnt_r <= div_cnt_r + 9'd1;
          end
        end
        ST_FINISH: begin
          idx_r     <= 4'd0;
          pending_r <= 1'b0;
          if (pending_r || start_s) begin
            state_r <= ST_LOAD;
          end else begin
            state_r     <= ST_IDLE;
            sample_en_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          idx_r       <= 4'd0;
          pending_r   <= 1'b0;
          busy_r      <= 1'b0;
          sample_en_r <= 1'b0;
          cs_n_r      <= 1'b1;
          sclk_r      <= 1'b0;
          sdata_r     <= 1'b0;
        end
      endcase
    end
  end

  assign CFG_CS_N  = cs_n_r;
  assign CFG_SCLK  = sclk_r;
  assign CFG_SDATA = sdata_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign SAMPLE_EN = sample_en_r;

endmodule
